uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one uart_tx transmitter.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the byte width.
REQ-003 The block SHALL have parameter TIMEOUT, default 120, giving the maximum WAIT cycles per byte (10 bits x 10 clk, plus margin).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  N_REQ  per-requester level request; requester k holds it until ack_o[k].
REQ-007 req_data_i  input  N_REQ*DATA_W  byte of requester k on bits [k*DATA_W +: DATA_W].
REQ-008 grant_o  output  N_REQ  one-hot owner, high from START through the end of WAIT.
REQ-009 ack_o  output  N_REQ  one-hot single-cycle pulse when the owner's byte is sent.
REQ-010 err_o  output  1  single-cycle pulse on transmitter timeout.
REQ-011 busy_o  output  1  high in START and WAIT.
REQ-012 tx_start_o  output  1  single-cycle start pulse to uart_tx.
REQ-013 tx_data_o  output  DATA_W  byte to uart_tx, held from START until the next grant.
REQ-014 tx_done_i  input  1  single-cycle completion pulse from uart_tx.

Function
REQ-015 The FSM SHALL have the states IDLE, START and WAIT.
REQ-016 In IDLE with any req_i bit high at cycle t, the FSM SHALL pick the first set bit at or after round-robin pointer ptr (wrapping modulo N_REQ), and SHALL latch the index and data.
REQ-017 Following a pick at cycle t, the block SHALL be in START at t+1 with tx_start_o=1, grant_o set and tx_data_o equal to the latched byte.
REQ-018 The FSM SHALL go from START to WAIT unconditionally after one cycle.
REQ-019 The WAIT timer SHALL clear on entering WAIT and increment by 1 each WAIT cycle.
REQ-020 On tx_done_i in WAIT, the block SHALL assert ack_o[owner] for the next cycle, clear grant_o, set ptr to (owner+1) mod N_REQ, and return to IDLE.
REQ-021 If the timer reaches TIMEOUT-1 in WAIT without tx_done_i, the block SHALL pulse err_o, SHALL NOT assert ack_o, SHALL advance ptr as in REQ-020, and SHALL return to IDLE.
REQ-022 When tx_done_i and timeout occur in the same cycle, done SHALL take priority: ack only, no err.
REQ-023 tx_done_i in IDLE or START SHALL be ignored.
REQ-024 Dropping req_i or changing req_data_i during ownership SHALL NOT abort the transfer; the latched byte is sent and ack still pulses.
REQ-025 Arbitration SHALL occur only in IDLE, so at least one IDLE cycle separates consecutive transfers.
REQ-026 req_i still high in IDLE after ack SHALL be treated as a new byte, subject to round-robin order.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0, state SHALL be IDLE, ptr SHALL be 0 and the timer SHALL be 0, asynchronously.
REQ-028 Reset during START or WAIT SHALL abort the transfer with no ack_o and no err_o pulse.

Structure
REQ-029 The shared package uart_pkg SHALL hold the FSM state encoding, the DATA_W default, the TIMEOUT default and the clocks-per-bit constant (10).
REQ-030 The round-robin selection SHALL be one combinational sub-module, uart_rr_pick (inputs req, ptr; output one-hot pick plus index).

Verification
REQ-031 The bench SHALL use a transmitter stub that pulses tx_done_i 100 cycles after tx_start_o.
REQ-032 Single request: req_i=4'b0001, data 8'h55 -> tx_start_o one cycle after req, tx_data_o=8'h55, ack_o=4'b0001 one cycle after done, busy_o low afterwards.
REQ-033 Simultaneous requests: req_i=4'b1111, data A0/A1/A2/A3 -> bytes sent in order A0, A1, A2, A3; each requester acked once; ptr back to 0.
REQ-034 Wrap-around: after requester 1 is served (ptr=2), req_i=4'b0011 -> requester 0 granted before requester 1.
REQ-035 Timeout: stub never pulses done -> err_o on WAIT cycle 120, no ack_o, busy_o low on the next cycle.
REQ-036 Reset mid-WAIT: rst_n=0 -> outputs 0 immediately, no ack; after release with req_i=4'b0100 held -> requester 2 re-served, ptr starting at 0.
REQ-037 Spurious done: tx_done_i pulsed in IDLE -> no ack_o, no state change.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART TX arbiter.
// No ports; imported by uart_rr_pick and uart_tx_arbiter.
package uart_pkg;

    localparam int CLKS_PER_BIT = 10;
    localparam int DATA_W_DEF   = 8;
    // start + data + stop bits at CLKS_PER_BIT each, plus margin
    localparam int TIMEOUT_DEF  = (DATA_W_DEF + 2) * CLKS_PER_BIT + 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin selector, first set req bit at/after ptr.
// Ports: req, ptr in; pick (one-hot), idx, valid out.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        pick,
    output logic [idx_w(N_REQ)-1:0] idx,
    output logic                    valid
);

    localparam int IW = idx_w(N_REQ);

    always_comb begin
        int j;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                idx     = IW'(j);
                pick[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ round-robin requesters.
// Ports: req_i/req_data_i in; grant_o, ack_o, err_o, busy_o, tx_start_o,
// tx_data_o out; tx_done_i completion pulse from the transmitter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    tx_start_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_done_i
);

    localparam int IW = idx_w(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    owner_nxt;
    logic [TW-1:0]    timer;
    logic [N_REQ-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign owner_nxt = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            timer      <= '0;
            grant_o    <= '0;
            ack_o      <= '0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            tx_start_o <= 1'b0;
            ack_o      <= '0;
            err_o      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner      <= pick_idx;
                        grant_o    <= pick;
                        tx_data_o  <= req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
                        tx_start_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done wins over a coinciding timeout
                    if (tx_done_i) begin
                        ack_o   <= grant_o;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        ptr     <= owner_nxt;
                        state   <= ST_IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err_o   <= 1'b1;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        ptr     <= owner_nxt;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench with a transaction-level model
// of round-robin service order, transmitter stub and reset cases.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic         tx_done_i = 1'b0;
    logic [N-1:0] grant_o;
    logic [N-1:0] ack_o;
    logic         err_o;
    logic         busy_o;
    logic         tx_start_o;
    logic [W-1:0] tx_data_o;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .TIMEOUT (120)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .grant_o    (grant_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (tx_done_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int stub_dly = 100;
    int dly_cnt  = 0;
    bit mute     = 1'b0;
    bit spur     = 1'b0;

    bit           st_seen, ak_seen, er_seen;
    int           st_cyc, ak_cyc, er_cyc;
    logic [N-1:0] st_grant, ak_val, ak_grant, owner_m;
    logic [W-1:0] st_data;
    logic         ak_busy, er_busy;

    int           m_ptr = 0;
    logic [W-1:0] mdata [N];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_first(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++)
            if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // one clock: stub, event capture, requester behaviour
    task automatic step();
        @(negedge clk);
        cyc++;
        tx_done_i = 1'b0;
        if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) tx_done_i = 1'b1;
        end
        if (spur) begin
            tx_done_i = 1'b1;
            spur = 1'b0;
        end
        if (tx_start_o && !mute) dly_cnt = stub_dly;
        if (tx_start_o) begin
            st_seen  = 1'b1;
            st_cyc   = cyc;
            st_grant = grant_o;
            st_data  = tx_data_o;
            owner_m  = grant_o;
            for (int j = 0; j < N; j++)
                if (grant_o[j]) req_data_i[j*W +: W] = W'($urandom);
        end
        if (|ack_o) begin
            ak_seen  = 1'b1;
            ak_cyc   = cyc;
            ak_val   = ack_o;
            ak_busy  = busy_o;
            ak_grant = grant_o;
            req_i    = req_i & ~ack_o;
        end
        if (err_o) begin
            er_seen = 1'b1;
            er_cyc  = cyc;
            er_busy = busy_o;
            req_i   = req_i & ~owner_m;
        end
    endtask

    task automatic chk_zero(input string p);
        check({p, "_grant"}, grant_o, 0);
        check({p, "_ack"}, ack_o, 0);
        check({p, "_err"}, err_o, 0);
        check({p, "_busy"}, busy_o, 0);
        check({p, "_start"}, tx_start_o, 0);
        check({p, "_data"}, tx_data_o, 0);
    endtask

    task automatic do_xfer(input int k, input int exp_st, input bit to_mode);
        st_seen = 1'b0;
        for (int n = 0; n < 300 && !st_seen; n++) step();
        check("start_seen", st_seen, 1);
        if (!st_seen) return;
        check("start_cyc", st_cyc, exp_st);
        check("grant", st_grant, 32'(1) << k);
        check("data", st_data, mdata[k]);
        ak_seen = 1'b0;
        er_seen = 1'b0;
        for (int n = 0; n < 300 && !ak_seen && !er_seen; n++) step();
        if (to_mode) begin
            check("err_seen", er_seen, 1);
            check("err_cyc", er_cyc, st_cyc + 121);
            check("err_busy", er_busy, 0);
            check("err_noack", ak_seen, 0);
        end else begin
            check("ack_seen", ak_seen, 1);
            check("ack_cyc", ak_cyc, st_cyc + stub_dly + 1);
            check("ack_val", ak_val, 32'(1) << k);
            check("ack_busy", ak_busy, 0);
            check("ack_grant", ak_grant, 0);
            check("ack_noerr", er_seen, 0);
        end
        m_ptr = (k + 1) % N;
    endtask

    task automatic serve(input logic [N-1:0] mask, input int base);
        logic [N-1:0] m;
        int p, k, exp_st;
        int order[$];
        for (int i = 0; i < N; i++) begin
            mdata[i] = (base < 0) ? W'($urandom) : W'(base + i);
            req_data_i[i*W +: W] = mdata[i];
        end
        m = mask;
        p = m_ptr;
        while (m != 0) begin
            k = rr_first(m, p);
            order.push_back(k);
            m[k] = 1'b0;
            p = (k + 1) % N;
        end
        req_i = mask;
        exp_st = cyc + 1;
        foreach (order[i]) begin
            do_xfer(order[i], exp_st, 1'b0);
            exp_st = ak_cyc + 1;
        end
        step();
        check("idle_busy", busy_o, 0);
    endtask

    task automatic pulse_reset(input string p);
        rst_n = 1'b0;
        #1;
        chk_zero(p);
        dly_cnt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    initial begin
        int k;
        repeat (3) step();
        chk_zero("rst");
        rst_n = 1'b1;
        step();

        serve(4'b0001, 8'h55);
        pulse_reset("rst2");
        serve(4'b1111, 8'hA0);
        serve(4'b0010, -1);
        serve(4'b0011, -1);

        for (int r = 0; r < 6; r++)
            serve(N'($urandom_range(1, 15)), -1);

        ak_seen = 1'b0;
        st_seen = 1'b0;
        spur = 1'b1;
        repeat (3) step();
        check("spur_ack", ak_seen, 0);
        check("spur_start", st_seen, 0);
        check("spur_busy", busy_o, 0);
        serve(N'($urandom_range(1, 15)), -1);

        mute = 1'b1;
        k = $urandom_range(0, N - 1);
        mdata[k] = W'($urandom);
        req_data_i[k*W +: W] = mdata[k];
        req_i = N'(1) << k;
        do_xfer(k, cyc + 1, 1'b1);
        mute = 1'b0;
        step();
        check("to_idle", busy_o, 0);
        serve(N'($urandom_range(1, 15)), -1);

        stub_dly = 120;
        serve(N'($urandom_range(1, 15)), -1);
        stub_dly = 100;

        mdata[2] = W'($urandom);
        req_data_i[2*W +: W] = mdata[2];
        req_i = 4'b0100;
        st_seen = 1'b0;
        for (int n = 0; n < 300 && !st_seen; n++) step();
        check("mid_start", st_seen, 1);
        repeat (50) step();
        ak_seen = 1'b0;
        er_seen = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        dly_cnt = 0;
        repeat (3) step();
        check("midrst_ack", ak_seen, 0);
        check("midrst_err", er_seen, 0);
        mdata[2] = req_data_i[2*W +: W];
        rst_n = 1'b1;
        m_ptr = 0;
        do_xfer(2, cyc + 1, 1'b0);
        step();

        pulse_reset("rst3");
        serve(4'b1010, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

endmodule
